// File: rtl/crop_sequencer_if.sv
// Engine-side bus of the crop sequencer: latched window, engine handshakes, the two
// engine write ports and the shared frame-memory write port.
interface crop_sequencer_if;
    logic [10:0] cx_min;
    logic [10:0] cx_max;
    logic [10:0] cy_min;
    logic [10:0] cy_max;

    logic        hdr_start;
    logic        hdr_done;
    logic [23:0] hdr_addr;
    logic        hdr_wren;
    logic [15:0] hdr_wrdata;

    logic        pix_start;
    logic        pix_done;
    logic [23:0] pix_addr;
    logic        pix_wren;
    logic [15:0] pix_wrdata;

    logic [23:0] mem_addr;
    logic        mem_wren;
    logic [15:0] mem_wrdata;

    modport master (
        output cx_min, cx_max, cy_min, cy_max,
        output hdr_start, pix_start,
        output mem_addr, mem_wren, mem_wrdata,
        input  hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
        input  pix_done, pix_addr, pix_wren, pix_wrdata
    );

    modport slave (
        input  cx_min, cx_max, cy_min, cy_max,
        input  hdr_start, pix_start,
        input  mem_addr, mem_wren, mem_wrdata,
        output hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
        output pix_done, pix_addr, pix_wren, pix_wrdata
    );
endinterface

// File: rtl/crop_sequencer.sv
// Crop-and-export run controller: validates the crop window, runs the header engine then the
// pixel engine, and owns the shared frame-memory write port.
module crop_sequencer #(
    parameter int unsigned WIDTH    = 100,
    parameter int unsigned HEIGHT   = 100,
    parameter int unsigned PIX_BASE = 54,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [10:0]      x_min_i,
    input  logic [10:0]      x_max_i,
    input  logic [10:0]      y_min_i,
    input  logic [10:0]      y_max_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    crop_sequencer_if.master bus_if
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StHdrGo,
        StHdrWait,
        StPixGo,
        StPixWait,
        StDone,
        StError
    } state_e;

    localparam logic [1:0]  ErrNone       = 2'd0;
    localparam logic [1:0]  ErrBounds     = 2'd1;
    localparam logic [1:0]  ErrHdrTimeout = 2'd2;
    localparam logic [1:0]  ErrPixTimeout = 2'd3;
    localparam logic [16:0] TimeoutCnt    = 17'(TIMEOUT);
    localparam logic [23:0] PixBase       = 24'(PIX_BASE);

    state_e      state_q, state_d;
    logic [10:0] cx_min_q, cx_min_d;
    logic [10:0] cx_max_q, cx_max_d;
    logic [10:0] cy_min_q, cy_min_d;
    logic [10:0] cy_max_q, cy_max_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hdr_done_q;
    logic        pix_done_q;

    logic        hdr_rise;
    logic        pix_rise;
    logic        win_ok;
    logic [16:0] cnt_inc;
    logic        cnt_expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cx_min_q   <= '0;
            cx_max_q   <= '0;
            cy_min_q   <= '0;
            cy_max_q   <= '0;
            err_code_q <= ErrNone;
            cnt_q      <= '0;
            hdr_done_q <= 1'b0;
            pix_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_min_q   <= cx_min_d;
            cx_max_q   <= cx_max_d;
            cy_min_q   <= cy_min_d;
            cy_max_q   <= cy_max_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
            hdr_done_q <= bus_if.hdr_done;
            pix_done_q <= bus_if.pix_done;
        end
    end

    // Only a fresh rising edge counts, so a done level left over from a prior run is ignored.
    assign hdr_rise = bus_if.hdr_done & ~hdr_done_q;
    assign pix_rise = bus_if.pix_done & ~pix_done_q;

    assign win_ok = (cx_min_q <= cx_max_q) && (32'(cx_max_q) < WIDTH) &&
                    (cy_min_q <= cy_max_q) && (32'(cy_max_q) < HEIGHT);

    // Extra bit keeps the compare exact even with TIMEOUT at the 16-bit maximum.
    assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
    assign cnt_expired = (cnt_inc >= TimeoutCnt);

    always_comb begin
        state_d    = state_q;
        cx_min_d   = cx_min_q;
        cx_max_d   = cx_max_q;
        cy_min_d   = cy_min_q;
        cy_max_d   = cy_max_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    cx_min_d   = x_min_i;
                    cx_max_d   = x_max_i;
                    cy_min_d   = y_min_i;
                    cy_max_d   = y_max_i;
                    err_code_d = ErrNone;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (win_ok) begin
                    state_d = StHdrGo;
                end else begin
                    err_code_d = ErrBounds;
                    state_d    = StError;
                end
            end
            StHdrGo: begin
                cnt_d   = '0;
                state_d = StHdrWait;
            end
            StHdrWait: begin
                if (hdr_rise) begin
                    state_d = StPixGo;
                end else if (cnt_expired) begin
                    err_code_d = ErrHdrTimeout;
                    state_d    = StError;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            StPixGo: begin
                cnt_d   = '0;
                state_d = StPixWait;
            end
            StPixWait: begin
                if (pix_rise) begin
                    state_d = StDone;
                end else if (cnt_expired) begin
                    err_code_d = ErrPixTimeout;
                    state_d    = StError;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o            = 1'b0;
        done_o            = 1'b0;
        err_o             = 1'b0;
        bus_if.hdr_start  = 1'b0;
        bus_if.pix_start  = 1'b0;
        bus_if.mem_addr   = '0;
        bus_if.mem_wren   = 1'b0;
        bus_if.mem_wrdata = '0;

        case (state_q)
            StCheck: busy_o = 1'b1;
            StHdrGo, StHdrWait: begin
                busy_o            = 1'b1;
                bus_if.hdr_start  = (state_q == StHdrGo);
                bus_if.mem_addr   = bus_if.hdr_addr;
                bus_if.mem_wren   = bus_if.hdr_wren;
                bus_if.mem_wrdata = bus_if.hdr_wrdata;
            end
            StPixGo, StPixWait: begin
                busy_o            = 1'b1;
                bus_if.pix_start  = (state_q == StPixGo);
                bus_if.mem_addr   = bus_if.pix_addr + PixBase;
                bus_if.mem_wren   = bus_if.pix_wren;
                bus_if.mem_wrdata = bus_if.pix_wrdata;
            end
            StDone:  done_o = 1'b1;
            StError: err_o  = 1'b1;
            default: ;
        endcase
    end

    assign err_code_o    = err_code_q;
    assign bus_if.cx_min = cx_min_q;
    assign bus_if.cx_max = cx_max_q;
    assign bus_if.cy_min = cy_min_q;
    assign bus_if.cy_max = cy_max_q;

endmodule

// File: tb/tb_crop_sequencer.sv
// Bench for crop_sequencer: engine models driven from the main thread, a scoreboard of expected
// frame-memory writes, and status/pulse checks for normal, error, stale-done and reset runs.
module tb_crop_sequencer;

    localparam int unsigned Width   = 100;
    localparam int unsigned Height  = 100;
    localparam int unsigned PixBase = 54;
    localparam int unsigned Timeout = 8;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic        busy, done, err;
    logic [1:0]  err_code;

    logic        hdr_done, hdr_wren, pix_done, pix_wren;
    logic [23:0] hdr_addr, pix_addr;
    logic [15:0] hdr_wrdata, pix_wrdata;

    crop_sequencer_if bus ();

    assign bus.hdr_done   = hdr_done;
    assign bus.hdr_addr   = hdr_addr;
    assign bus.hdr_wren   = hdr_wren;
    assign bus.hdr_wrdata = hdr_wrdata;
    assign bus.pix_done   = pix_done;
    assign bus.pix_addr   = pix_addr;
    assign bus.pix_wren   = pix_wren;
    assign bus.pix_wrdata = pix_wrdata;

    crop_sequencer #(
        .WIDTH   (Width),
        .HEIGHT  (Height),
        .PIX_BASE(PixBase),
        .TIMEOUT (Timeout)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .x_min_i   (x_min),
        .x_max_i   (x_max),
        .y_min_i   (y_min),
        .y_max_i   (y_max),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .err_code_o(err_code),
        .bus_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errs   = 0;
    int  n_hdr_start = 0;
    int  n_pix_start = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expd);
        n_checks++;
        if (act !== expd) begin
            n_errs++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, act, expd);
        end
    endtask

    // Every frame-memory write must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.hdr_start) n_hdr_start++;
        if (bus.pix_start) n_pix_start++;
        if (bus.mem_wren) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(bus.mem_wren), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(bus.mem_wrdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic b, input logic d, input logic e,
                          input logic [1:0] c);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_code"}, 32'(err_code), 32'(c));
    endtask

    // Returns at posedge+1 of the cycle after the awaited signal was seen high.
    task automatic wait_sig(input string tag, input int which, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = bus.hdr_start;
                1:       seen = bus.pix_start;
                2:       seen = done;
                default: seen = err;
            endcase
        end
        check(tag, 32'(seen), 32'd1);
        tick();
    endtask

    // Leaves the bench in the CHECK cycle; raw bounds are scrambled afterwards.
    task automatic pulse_start(input logic [10:0] a, input logic [10:0] b,
                               input logic [10:0] c, input logic [10:0] d);
        x_min = a;
        x_max = b;
        y_min = c;
        y_max = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_min = 11'($urandom);
        x_max = 11'($urandom);
        y_min = 11'($urandom);
        y_max = 11'($urandom);
    endtask

    task automatic bad_run(input string tag, input logic [10:0] a, input logic [10:0] b,
                           input logic [10:0] c, input logic [10:0] d);
        int hs;
        hs = n_hdr_start;
        pulse_start(a, b, c, d);
        @(negedge clk);
        status({tag, "_chk"}, 1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        @(negedge clk);
        status({tag, "_err"}, 1'b0, 1'b0, 1'b1, 2'd1);
        check({tag, "_no_hdr"}, 32'(n_hdr_start), 32'(hs));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        {x_min, x_max, y_min, y_max} = '0;
        {hdr_done, hdr_wren, pix_done, pix_wren} = '0;
        hdr_addr = '0;
        pix_addr = '0;
        hdr_wrdata = '0;
        pix_wrdata = '0;
        repeat (3) tick();
        @(negedge clk);
        status("rst", 1'b0, 1'b0, 1'b0, 2'd0);
        check("rst_cx", 32'({bus.cx_min, bus.cx_max, bus.cy_min}), 32'd0);
        check("rst_cymax", 32'(bus.cy_max), 32'd0);
        check("rst_starts", 32'({bus.hdr_start, bus.pix_start, bus.mem_wren}), 32'd0);
        rst = 1'b0;
        tick();

        // Normal run, with pixel-engine cross-talk during the header phase.
        pulse_start(11'd10, 11'd49, 11'd20, 11'd59);
        wait_sig("n_hdr_start", 0, 4);
        pix_wren = 1'b1;
        pix_addr = 24'h000777;
        pix_wrdata = 16'hDEAD;
        for (int k = 0; k < 4; k++) begin
            hdr_wren = (k != 2);
            hdr_addr = 24'(k);
            hdr_wrdata = 16'h4200 + 16'(k);
            if (k != 2) exp_q.push_back('{addr: 24'(k), data: 16'h4200 + 16'(k)});
            hdr_done = (k == 3);
            if (k < 3) tick();
        end
        tick();
        pix_wren = 1'b0;
        hdr_wren = 1'b1;
        hdr_addr = 24'd999;
        wait_sig("n_pix_start", 1, 2);
        for (int k = 0; k < 3; k++) begin
            pix_wren = 1'b1;
            pix_addr = 24'(k);
            pix_wrdata = 16'h5100 + 16'(k);
            exp_q.push_back('{addr: 24'(PixBase + k), data: 16'h5100 + 16'(k)});
            tick();
        end
        pix_wren = 1'b0;
        hdr_wren = 1'b0;
        pix_done = 1'b1;
        wait_sig("n_done", 2, 4);
        status("n_end", 1'b0, 1'b1, 1'b0, 2'd0);
        check("n_cx", 32'({bus.cx_min, bus.cx_max}), 32'({11'd10, 11'd49}));
        check("n_cy", 32'({bus.cy_min, bus.cy_max}), 32'({11'd20, 11'd59}));
        check("n_pulses", 32'({8'(n_hdr_start), 8'(n_pix_start)}), 32'h0101);
        check("n_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stale done levels from the previous run plus a start while busy.
        pulse_start(11'd0, 11'd99, 11'd0, 11'd99);
        @(negedge clk);
        status("s_chk", 1'b1, 1'b0, 1'b0, 2'd0);
        wait_sig("s_hdr_start", 0, 3);
        tick();
        hdr_done = 1'b0;
        tick();
        @(negedge clk);
        check("s_stale_hdr", 32'(n_pix_start), 32'd1);
        tick();
        hdr_done = 1'b1;
        wait_sig("s_pix_start", 1, 2);
        x_min = 11'd5;
        x_max = 11'd6;
        y_min = 11'd7;
        y_max = 11'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_done = 1'b0;
        @(negedge clk);
        check("s_busy_start", 32'(busy), 32'd1);
        check("s_cx", 32'({bus.cx_min, bus.cx_max}), 32'({11'd0, 11'd99}));
        check("s_cy", 32'({bus.cy_min, bus.cy_max}), 32'({11'd0, 11'd99}));
        tick();
        pix_done = 1'b1;
        wait_sig("s_done", 2, 3);
        status("s_end", 1'b0, 1'b1, 1'b0, 2'd0);

        // Invalid windows never start the header engine.
        bad_run("b_xswap", 11'd50, 11'd40, 11'd0, 11'd10);
        bad_run("b_xmax", 11'd0, 11'd100, 11'd0, 11'd10);
        bad_run("b_yswap", 11'd0, 11'd10, 11'd60, 11'd59);
        bad_run("b_ymax", 11'd0, 11'd10, 11'd0, 11'd100);

        // Header timeout.
        hdr_done = 1'b0;
        pix_done = 1'b0;
        pulse_start(11'd1, 11'd2, 11'd3, 11'd4);
        wait_sig("th_hdr_start", 0, 3);
        repeat (7) tick();
        @(negedge clk);
        status("th_pre", 1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        @(negedge clk);
        status("th_err", 1'b0, 1'b0, 1'b1, 2'd2);
        check("th_no_pix", 32'(n_pix_start), 32'd2);

        // Pixel timeout.
        pulse_start(11'd1, 11'd2, 11'd3, 11'd4);
        wait_sig("tp_hdr_start", 0, 3);
        hdr_done = 1'b1;
        wait_sig("tp_pix_start", 1, 3);
        repeat (7) tick();
        @(negedge clk);
        status("tp_pre", 1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        @(negedge clk);
        status("tp_err", 1'b0, 1'b0, 1'b1, 2'd3);
        hdr_done = 1'b0;

        // Reset in PIX_WAIT: the write in the reset cycle still lands, nothing after it.
        tick();
        pulse_start(11'd10, 11'd49, 11'd20, 11'd59);
        wait_sig("r_hdr_start", 0, 3);
        hdr_done = 1'b1;
        wait_sig("r_pix_start", 1, 3);
        hdr_done = 1'b0;
        rst = 1'b1;
        pix_wren = 1'b1;
        pix_addr = 24'd5;
        pix_wrdata = 16'h7777;
        exp_q.push_back('{addr: 24'(PixBase + 5), data: 16'h7777});
        tick();
        rst = 1'b0;
        @(negedge clk);
        status("r_idle", 1'b0, 1'b0, 1'b0, 2'd0);
        check("r_cx", 32'({bus.cx_min, bus.cx_max}), 32'd0);
        check("r_outs", 32'({bus.hdr_start, bus.pix_start, bus.mem_wren}), 32'd0);
        check("r_addr", 32'(bus.mem_addr), 32'd0);
        pix_wren = 1'b0;
        tick();

        // Clean restart after reset.
        pulse_start(11'd3, 11'd4, 11'd5, 11'd6);
        wait_sig("c_hdr_start", 0, 3);
        hdr_done = 1'b1;
        wait_sig("c_pix_start", 1, 3);
        pix_done = 1'b1;
        wait_sig("c_done", 2, 3);
        status("c_end", 1'b0, 1'b1, 1'b0, 2'd0);
        check("c_cx", 32'({bus.cx_min, bus.cx_max}), 32'({11'd3, 11'd4}));
        check("c_pulses", 32'({8'(n_hdr_start), 8'(n_pix_start)}), 32'h0605);
        check("c_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
